// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and defaults for the EX-stage hazard and mul/div sequencer.
// Pure definitions: no logic, no latency, no flow control.
package ex_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE     = 2'd0,
        MD_MUL_WAIT = 2'd1,
        MD_DIV_WAIT = 2'd2,
        MD_DONE     = 2'd3
    } md_state_e;

    localparam int MUL_LAT_DEFAULT = 3;
    // Wide enough for the largest legal multiply latency (15).
    localparam int MD_CNT_W = 4;

endpackage

// File: rtl/ex_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare between the EX load destination and the ID sources.
// Latency: combinational; backpressure: none, result feeds the stall decode.
module ex_hazard_ctrl_load_use_detect (
    input  logic [4:0] id_rs1_add_i,
    input  logic [4:0] id_rs2_add_i,
    input  logic [4:0] ex_rd_add_i,
    input  logic       ex_rd_mem_i,
    output logic       hazard_o
);

    logic rd_nonzero;
    logic rs_match;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign rd_nonzero = (ex_rd_add_i != 5'd0);
    assign rs_match   = (ex_rd_add_i == id_rs1_add_i) || (ex_rd_add_i == id_rs2_add_i);
    assign hazard_o   = ex_rd_mem_i && rd_nonzero && rs_match;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencer: load-use bubbles, branch flushes and mul/div start/wait/done.
// Latency: controls combinational from state; backpressure: holds PC..ID/EX while mul/div busy.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_add_i,
    input  logic [4:0]       id_rs2_add_i,
    input  logic [4:0]       ex_rd_add_i,
    input  logic             ex_rd_mem_i,
    input  logic             ex_md_req_i,
    input  logic             ex_md_is_div_i,
    input  logic             md_done_i,
    input  logic             mem_branch_taken_i,
    output logic             md_start_o,
    output logic             md_kill_o,
    output logic             md_busy_o,
    output logic             stall_pc_o,
    output logic             stall_ifid_o,
    output logic             stall_idex_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic             flush_exmem_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_LAT - 1);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                  load_use;

    ex_hazard_ctrl_load_use_detect u_load_use_detect (
        .id_rs1_add_i (id_rs1_add_i),
        .id_rs2_add_i (id_rs2_add_i),
        .ex_rd_add_i  (ex_rd_add_i),
        .ex_rd_mem_i  (ex_rd_mem_i),
        .hazard_o     (load_use)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        md_start_o    = 1'b0;
        md_kill_o     = 1'b0;
        md_busy_o     = 1'b0;
        stall_pc_o    = 1'b0;
        stall_ifid_o  = 1'b0;
        stall_idex_o  = 1'b0;
        flush_ifid_o  = 1'b0;
        flush_idex_o  = 1'b0;
        flush_exmem_o = 1'b0;

        // A taken branch outranks everything: front-end flush, no stalls.
        case (state_q)
            MD_IDLE: begin
                if (mem_branch_taken_i) begin
                    flush_ifid_o = 1'b1;
                    flush_idex_o = 1'b1;
                end else if (ex_md_req_i) begin
                    md_start_o    = 1'b1;
                    stall_pc_o    = 1'b1;
                    stall_ifid_o  = 1'b1;
                    stall_idex_o  = 1'b1;
                    flush_exmem_o = 1'b1;
                    if (ex_md_is_div_i) begin
                        state_d = MD_DIV_WAIT;
                    end else begin
                        state_d = MD_MUL_WAIT;
                        cnt_d   = MUL_LOAD;
                    end
                end else if (load_use) begin
                    stall_pc_o   = 1'b1;
                    stall_ifid_o = 1'b1;
                    flush_idex_o = 1'b1;
                end
            end
            MD_MUL_WAIT, MD_DIV_WAIT: begin
                md_busy_o = 1'b1;
                if (mem_branch_taken_i) begin
                    md_kill_o    = 1'b1;
                    flush_ifid_o = 1'b1;
                    flush_idex_o = 1'b1;
                    state_d      = MD_IDLE;
                    cnt_d        = '0;
                end else begin
                    stall_pc_o    = 1'b1;
                    stall_ifid_o  = 1'b1;
                    stall_idex_o  = 1'b1;
                    flush_exmem_o = 1'b1;
                    if (state_q == MD_MUL_WAIT) begin
                        if (cnt_q == '0) begin
                            state_d = MD_DONE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end else if (md_done_i) begin
                        state_d = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                // EX/MEM captures the result this cycle; a new request waits for IDLE.
                state_d = MD_IDLE;
                if (mem_branch_taken_i) begin
                    flush_ifid_o = 1'b1;
                    flush_idex_o = 1'b1;
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase

        stall_cnt_d = stall_cnt_q + CNT_W'(stall_pc_o);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
